// File: rtl/mul_share_pkg.sv
// Shared types and constants for the two-requester multiplier-sharing arbiter.
package mul_share_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    CALC2 = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic REQ0      = 1'b0;
  localparam logic REQ1      = 1'b1;
  localparam int   DEF_WIDTH = 8;

endpackage

// File: rtl/mul_rr_arb2.sv
// Two-way round-robin grant: a lone requester wins; on contention the one
// that was not granted last wins. Purely combinational.
module mul_rr_arb2
  import mul_share_pkg::*;
(
  input  logic [1:0] req,
  input  logic       ptr,
  output logic       gnt_vld,
  output logic       gnt_idx
);

  always_comb begin
    gnt_vld = |req;
    gnt_idx = REQ0;
    case (req)
      2'b01:   gnt_idx = REQ0;
      2'b10:   gnt_idx = REQ1;
      2'b11:   gnt_idx = ~ptr;
      default: gnt_idx = REQ0;
    endcase
  end

endmodule

// File: rtl/mul_share_arbiter.sv
// Shares one external WIDTHxWIDTH multiplier between two valid/ready requesters.
// Define MUL_PIPE_EN to register the multiplier output for one extra cycle (CALC2).
module mul_share_arbiter
  import mul_share_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter bit FIRST_PRIO = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               r0_valid,
  output logic               r0_ready,
  input  logic [WIDTH-1:0]   r0_a,
  input  logic [WIDTH-1:0]   r0_b,
  output logic               r0_rsp_valid,
  input  logic               r0_rsp_ready,
  output logic [2*WIDTH-1:0] r0_rsp_p,
  input  logic               r1_valid,
  output logic               r1_ready,
  input  logic [WIDTH-1:0]   r1_a,
  input  logic [WIDTH-1:0]   r1_b,
  output logic               r1_rsp_valid,
  input  logic               r1_rsp_ready,
  output logic [2*WIDTH-1:0] r1_rsp_p,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  input  logic [2*WIDTH-1:0] mul_p,
  output logic               busy
);

  localparam logic PTR_RST = ~FIRST_PRIO;

  state_t               state_q, state_d;
  logic                 ptr_q, ptr_d;
  logic                 gnt_q, gnt_d;
  logic [WIDTH-1:0]     op_a_q, op_a_d;
  logic [WIDTH-1:0]     op_b_q, op_b_d;
  logic [2*WIDTH-1:0]   rsp0_q, rsp0_d;
  logic [2*WIDTH-1:0]   rsp1_q, rsp1_d;
`ifdef MUL_PIPE_EN
  logic [2*WIDTH-1:0]   mulp_q, mulp_d;
`endif

  logic                 arb_vld;
  logic                 arb_idx;
  logic                 cap_en;
  logic [2*WIDTH-1:0]   cap_val;

  mul_rr_arb2 u_arb (
    .req     ({r1_valid, r0_valid}),
    .ptr     (ptr_q),
    .gnt_vld (arb_vld),
    .gnt_idx (arb_idx)
  );

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    gnt_d        = gnt_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    rsp0_d       = rsp0_q;
    rsp1_d       = rsp1_q;
`ifdef MUL_PIPE_EN
    mulp_d       = mulp_q;
`endif
    r0_ready     = 1'b0;
    r1_ready     = 1'b0;
    r0_rsp_valid = 1'b0;
    r1_rsp_valid = 1'b0;
    cap_en       = 1'b0;
    cap_val      = mul_p;

    case (state_q)
      IDLE: begin
        // Ready is gated by rst so nothing is accepted while reset is held.
        if (arb_vld && !rst) begin
          if (arb_idx == REQ0) begin
            r0_ready = 1'b1;
            op_a_d   = r0_a;
            op_b_d   = r0_b;
          end else begin
            r1_ready = 1'b1;
            op_a_d   = r1_a;
            op_b_d   = r1_b;
          end
          gnt_d   = arb_idx;
          ptr_d   = arb_idx;
          state_d = CALC;
        end
      end
      CALC: begin
`ifdef MUL_PIPE_EN
        mulp_d  = mul_p;
        state_d = CALC2;
`else
        cap_en  = 1'b1;
        state_d = RESP;
`endif
      end
      CALC2: begin
`ifdef MUL_PIPE_EN
        cap_en  = 1'b1;
        cap_val = mulp_q;
        state_d = RESP;
`else
        state_d = IDLE;
`endif
      end
      RESP: begin
        if (gnt_q == REQ0) begin
          r0_rsp_valid = 1'b1;
          if (r0_rsp_ready) state_d = IDLE;
        end else begin
          r1_rsp_valid = 1'b1;
          if (r1_rsp_ready) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Each port keeps its own product so the idle port's rsp_p never changes.
    if (cap_en) begin
      if (gnt_q == REQ0) rsp0_d = cap_val;
      else               rsp1_d = cap_val;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= PTR_RST;
      gnt_q   <= REQ0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      rsp0_q  <= '0;
      rsp1_q  <= '0;
`ifdef MUL_PIPE_EN
      mulp_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      rsp0_q  <= rsp0_d;
      rsp1_q  <= rsp1_d;
`ifdef MUL_PIPE_EN
      mulp_q  <= mulp_d;
`endif
    end
  end

  assign mul_a    = op_a_q;
  assign mul_b    = op_b_q;
  assign r0_rsp_p = rsp0_q;
  assign r1_rsp_p = rsp1_q;
  assign busy     = (state_q != IDLE);

endmodule
